// File: rtl/io_select_multi.sv
// I/O-mapped chip-select controller: relocatable base, NUM_SEL channels, bootstrap override, pulse mode.
// Optional bootstrap auto-exit counter enabled by defining BOOT_TIMEOUT_EN.
module io_select_multi #(
  parameter int          NUM_SEL     = 4,
  parameter int          PULSE_LEN   = 16,
  parameter logic [14:0] BOOT_MASK   = 15'b000_0000_0000_0011,
  parameter int          BOOT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        addr,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic               data_oe,
  input  logic               readio,
  input  logic               writeio,
  output logic [NUM_SEL-1:0] select,
  output logic               bootstrap
);

  typedef enum logic [1:0] {IDLE, WR_HOLD, RD_HOLD} state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN);
  localparam logic [3:0] MAX_OFF    = 4'(NUM_SEL);

  state_t state_q, state_d;
  logic [3:0] base_q, base_d;
  logic       boot_q, boot_d;
  logic [3:0] stg_off_q, stg_off_d;
  logic [7:0] stg_data_q, stg_data_d;
  logic [7:0] data_out_q, data_out_d;
  logic [NUM_SEL-1:0] en_vec, pulse_vec;
  logic [7:0] rd_val;
  logic       hit, commit, main_wr;
  logic       unused_ok;

  assign hit       = (addr[7:4] == base_q) && (addr[3:0] <= MAX_OFF);
  assign commit    = (state_q == WR_HOLD) && !writeio;
  assign main_wr   = commit && (stg_off_q == 4'd0);
  assign unused_ok = ^{addr[15:8], stg_data_q[3:2]};

  always_comb begin
    rd_val = {base_q, 3'b000, boot_q};
    for (int i = 0; i < NUM_SEL; i++) begin
      if (addr[3:0] == 4'(i + 1)) rd_val = {6'b0, pulse_vec[i], en_vec[i]};
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      stg_off_q  <= 4'd0;
      stg_data_q <= 8'd0;
      data_out_q <= 8'd0;
      base_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      stg_off_q  <= stg_off_d;
      stg_data_q <= stg_data_d;
      data_out_q <= data_out_d;
      base_q     <= base_d;
    end
  end

  // Next-state logic: a write cycle is staged and only committed once the strobe drops
  always_comb begin
    state_d    = state_q;
    stg_off_d  = stg_off_q;
    stg_data_d = stg_data_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (writeio && hit) begin
          state_d    = WR_HOLD;
          stg_off_d  = addr[3:0];
          stg_data_d = data_in;
        end else if (readio && hit) begin
          state_d    = RD_HOLD;
          data_out_d = rd_val;
        end
      end
      WR_HOLD: if (!writeio) state_d = IDLE;
      RD_HOLD: if (!readio) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    data_oe   = (state_q == RD_HOLD) && readio;
    data_out  = data_out_q;
    bootstrap = boot_q;
  end

  assign base_d = main_wr ? stg_data_q[7:4] : base_q;

`ifdef BOOT_TIMEOUT_EN
  localparam logic [15:0] BOOT_LAST = 16'(BOOT_CYCLES - 1);
  logic [15:0] boot_cnt_q, boot_cnt_d;
  logic        boot_stop_q, boot_stop_d;

  // A committed main-register write freezes the timeout for good
  always_comb begin
    boot_d      = boot_q;
    boot_cnt_d  = boot_cnt_q;
    boot_stop_d = boot_stop_q;
    if (main_wr) begin
      boot_d      = stg_data_q[0];
      boot_stop_d = 1'b1;
    end else if (boot_q && !boot_stop_q) begin
      if (boot_cnt_q == BOOT_LAST) begin
        boot_d     = 1'b0;
        boot_cnt_d = 16'(BOOT_CYCLES);
      end else begin
        boot_cnt_d = boot_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      boot_q      <= 1'b1;
      boot_cnt_q  <= 16'd0;
      boot_stop_q <= 1'b0;
    end else begin
      boot_q      <= boot_d;
      boot_cnt_q  <= boot_cnt_d;
      boot_stop_q <= boot_stop_d;
    end
  end
`else
  assign boot_d = main_wr ? stg_data_q[0] : boot_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) boot_q <= 1'b1;
    else        boot_q <= boot_d;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEL; gi++) begin : g_ch
      localparam logic [3:0] CH_OFF = 4'(gi + 1);
      logic       ch_wr;
      logic       en_q, en_d, pulse_q, pulse_d;
      logic [7:0] cnt_q, cnt_d;

      assign ch_wr = commit && (stg_off_q == CH_OFF);

      // Counter is nonzero only while a pulse is running; en drops on the 1->0 step
      always_comb begin
        en_d    = en_q;
        pulse_d = pulse_q;
        cnt_d   = cnt_q;
        if (ch_wr) begin
          en_d    = stg_data_q[0];
          pulse_d = stg_data_q[1];
          cnt_d   = (stg_data_q[0] && stg_data_q[1]) ? PULSE_LOAD : 8'd0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) en_d = 1'b0;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          en_q    <= 1'b0;
          pulse_q <= 1'b0;
          cnt_q   <= 8'd0;
        end else begin
          en_q    <= en_d;
          pulse_q <= pulse_d;
          cnt_q   <= cnt_d;
        end
      end

      assign en_vec[gi]    = en_q;
      assign pulse_vec[gi] = pulse_q;
      assign select[gi]    = en_q | (boot_q & BOOT_MASK[gi]);
    end
  endgenerate

endmodule

// File: tb/tb_io_select_multi.sv
// Self-checking bench for io_select_multi: directed vector table, hand-written corner sequences,
// and randomized bus cycles checked against a cycle-stamped behavioural model.
module tb_io_select_multi;

  localparam int NUM_SEL   = 4;
  localparam int PULSE_LEN = 16;
  localparam int BOOT_CYC  = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  data_in = 8'h0;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        readio = 1'b0;
  logic        writeio = 1'b0;
  logic [NUM_SEL-1:0] select;
  logic        bootstrap;

  io_select_multi #(
    .NUM_SEL(NUM_SEL), .PULSE_LEN(PULSE_LEN),
    .BOOT_MASK(15'b000_0000_0000_0011), .BOOT_CYCLES(BOOT_CYC)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .readio(readio), .writeio(writeio),
    .select(select), .bootstrap(bootstrap)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a pulse is an absolute expiry stamp on the edge counter
  logic [3:0] base_m;
  bit         boot_m;
  bit         en_bit [NUM_SEL];
  bit         pls    [NUM_SEL];
  int         expire [NUM_SEL];
  logic [3:0] boot_mask_v = 4'b0011;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    base_m = 4'h0;
    boot_m = 1'b1;
    for (int i = 0; i < NUM_SEL; i++) begin
      en_bit[i] = 1'b0; pls[i] = 1'b0; expire[i] = 0;
    end
  endtask

  function automatic bit en_now(input int i);
    return en_bit[i] | (cyc < expire[i]);
  endfunction

  function automatic logic [3:0] model_sel();
    logic [3:0] s;
    for (int i = 0; i < NUM_SEL; i++) s[i] = en_now(i) | (boot_m & boot_mask_v[i]);
    return s;
  endfunction

  function automatic bit model_hit(input logic [15:0] a);
    return (a[7:4] == base_m) && (int'(a[3:0]) <= NUM_SEL);
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] off);
    if (off == 4'd0) return {base_m, 3'b000, boot_m};
    return {6'b0, pls[off-1], en_now(int'(off) - 1)};
  endfunction

  task automatic model_commit(input logic [3:0] off, input logic [7:0] d);
    int i;
    if (off == 4'd0) begin
      base_m = d[7:4];
      boot_m = d[0];
    end else begin
      i = int'(off) - 1;
      pls[i] = d[1];
      if (d[0] && d[1]) begin en_bit[i] = 1'b0; expire[i] = cyc + PULSE_LEN; end
      else              begin en_bit[i] = d[0]; expire[i] = 0; end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " select"}, 32'(select), 32'(model_sel()));
    check({tag, " bootstrap"}, 32'(bootstrap), 32'(boot_m));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold, input bit also_rd);
    bit hitw;
    hitw = model_hit(a);
    @(negedge clock);
    addr = a; data_in = d; writeio = 1'b1; readio = also_rd & hitw;
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      check_state("wr_hold");
      check("wr_hold data_oe", 32'(data_oe), 32'd0);
      if (hitw) begin addr = 16'($urandom); data_in = 8'($urandom); end
    end
    @(negedge clock);
    writeio = 1'b0; readio = 1'b0; addr = 16'h0;
    @(negedge clock);
    if (hitw) model_commit(a[3:0], d);
    check_state("wr_commit");
    $display("write addr=%04h data=%02h hit=%0d select=%b bootstrap=%0d", a, d, hitw, select, bootstrap);
  endtask

  task automatic do_read(input logic [15:0] a, input int hold, output logic [7:0] rd, output logic oe);
    bit hitr;
    logic [7:0] exp;
    hitr = model_hit(a);
    exp  = model_read(a[3:0]);
    @(negedge clock);
    addr = a; readio = 1'b1;
    @(negedge clock);
    rd = data_out; oe = data_oe;
    check("rd data_oe", 32'(data_oe), 32'(hitr));
    if (hitr) check("rd data_out", 32'(data_out), 32'(exp));
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      check_state("rd_hold");
      check("rd_hold data_oe", 32'(data_oe), 32'(hitr));
      if (hitr) check("rd_hold data_out", 32'(data_out), 32'(exp));
    end
    readio = 1'b0;
    #1 check("rd drop data_oe", 32'(data_oe), 32'd0);
    @(negedge clock);
    addr = 16'h0;
    $display("read  addr=%04h data_out=%02h data_oe=%0d", a, rd, oe);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
    bit          exp_oe;
    logic [3:0]  exp_sel;
    bit          exp_boot;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic oe;
    int c1, c2, n_hi;

    vecs[0]  = '{1'b0, 16'h0000, 8'h00, 8'h01, 1'b1, 4'b0011, 1'b1};
    vecs[1]  = '{1'b0, 16'h0001, 8'h00, 8'h00, 1'b1, 4'b0011, 1'b1};
    vecs[2]  = '{1'b0, 16'h0005, 8'h00, 8'h00, 1'b0, 4'b0011, 1'b1};
    vecs[3]  = '{1'b1, 16'h0000, 8'hA0, 8'h00, 1'b0, 4'b0000, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b0};
    vecs[5]  = '{1'b0, 16'h00A0, 8'h00, 8'hA0, 1'b1, 4'b0000, 1'b0};
    vecs[6]  = '{1'b1, 16'h00A3, 8'h01, 8'h00, 1'b0, 4'b0100, 1'b0};
    vecs[7]  = '{1'b0, 16'h00A3, 8'h00, 8'h01, 1'b1, 4'b0100, 1'b0};
    vecs[8]  = '{1'b1, 16'h00A3, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b0};
    vecs[9]  = '{1'b1, 16'h00A7, 8'h01, 8'h00, 1'b0, 4'b0000, 1'b0};
    vecs[10] = '{1'b0, 16'h00A4, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0};
    vecs[11] = '{1'b1, 16'h12A4, 8'h01, 8'h00, 1'b0, 4'b1000, 1'b0};
    vecs[12] = '{1'b1, 16'h00A4, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b0};

    model_reset();
    repeat (3) @(negedge clock);
    check("reset select", 32'(select), 32'h3);
    check("reset bootstrap", 32'(bootstrap), 32'd1);
    check("reset data_oe", 32'(data_oe), 32'd0);
    check("reset data_out", 32'(data_out), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_state("post_reset");

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].wr) begin
        do_write(vecs[v].a, vecs[v].d, 2, 1'b0);
      end else begin
        do_read(vecs[v].a, 1, rd, oe);
        check($sformatf("vec%0d data_oe", v), 32'(oe), 32'(vecs[v].exp_oe));
        if (vecs[v].exp_oe) check($sformatf("vec%0d data_out", v), 32'(rd), 32'(vecs[v].exp_rd));
      end
      check($sformatf("vec%0d select", v), 32'(select), 32'(vecs[v].exp_sel));
      check($sformatf("vec%0d bootstrap", v), 32'(bootstrap), 32'(vecs[v].exp_boot));
    end

    // Pulse: select[0] high for exactly PULSE_LEN samples starting at the commit edge
    do_write(16'h00A1, 8'h03, 1, 1'b0);
    check("pulse k0", 32'(select[0]), 32'd1);
    for (int k = 1; k < PULSE_LEN; k++) begin
      @(negedge clock);
      check($sformatf("pulse k%0d", k), 32'(select[0]), 32'd1);
    end
    @(negedge clock);
    check("pulse expired", 32'(select[0]), 32'd0);
    do_read(16'h00A1, 0, rd, oe);
    check("pulse readback", 32'(rd), 32'h02);

    // Restart: rewrite 10 cycles in, then count the high samples from the second commit
    do_write(16'h00A1, 8'h03, 1, 1'b0);
    c1 = cyc;
    while (cyc < c1 + 10) begin
      @(negedge clock);
      check_state("restart wait");
    end
    do_write(16'h00A1, 8'h03, 1, 1'b0);
    c2 = cyc;
    n_hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (select[0]) n_hi++;
      check_state("restart run");
      @(negedge clock);
    end
    check("restart high cycles", 32'(n_hi), 32'(PULSE_LEN));
    check("restart spacing", 32'(c2 > c1 + 9), 32'd1);

    // Abort a running pulse
    do_write(16'h00A1, 8'h03, 1, 1'b0);
    repeat (3) @(negedge clock);
    do_write(16'h00A1, 8'h00, 1, 1'b0);
    check("abort select0", 32'(select[0]), 32'd0);
    do_read(16'h00A1, 0, rd, oe);
    check("abort readback", 32'(rd), 32'h00);

    // Write wins over simultaneous read
    do_write(16'h00A2, 8'h01, 2, 1'b1);
    check("priority select", 32'(select), 32'b0010);
    do_read(16'h00A2, 0, rd, oe);
    check("priority readback", 32'(rd), 32'h01);
    do_write(16'h00A2, 8'h00, 1, 1'b0);

    // Reset during WR_HOLD with the strobe dropped before release: nothing commits
    @(negedge clock);
    addr = 16'h00A2; data_in = 8'h01; writeio = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid select", 32'(select), 32'b0011);
    check("rst_mid bootstrap", 32'(bootstrap), 32'd1);
    check("rst_mid data_oe", 32'(data_oe), 32'd0);
    writeio = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_after select", 32'(select), 32'b0011);
    do_read(16'h0000, 0, rd, oe);
    check("rst_after main", 32'(rd), 32'h01);

    // Reset with the strobe still high after release: treated as a fresh write cycle
    @(negedge clock);
    addr = 16'h0003; data_in = 8'h01; writeio = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    writeio = 1'b0;
    @(negedge clock);
    model_commit(4'd3, 8'h01);
    check("rst_new_cycle select", 32'(select), 32'b0111);
    check_state("rst_new_cycle");

    do_write(16'h0000, 8'h51, 1, 1'b0);

    // Randomized traffic against the model
    for (int t = 0; t < 80; t++) begin
      logic [15:0] a;
      logic [7:0]  d;
      if ($urandom_range(0, 9) < 8) a = {8'($urandom), base_m, 4'($urandom_range(0, 7))};
      else                          a = 16'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(a, d, $urandom_range(1, 3), $urandom_range(0, 3) == 0);
      else                           do_read(a, $urandom_range(0, 2), rd, oe);
      repeat ($urandom_range(0, 4)) begin
        @(negedge clock);
        check_state("gap");
      end
    end

`ifdef BOOT_TIMEOUT_EN
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    c1 = cyc;
    while (cyc < c1 + BOOT_CYC - 1) @(negedge clock);
    check("boot_to before", 32'(bootstrap), 32'd1);
    @(negedge clock);
    check("boot_to expired", 32'(bootstrap), 32'd0);

    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    c1 = cyc;
    while (cyc < c1 + 20) @(negedge clock);
    do_write(16'h0000, 8'h01, 1, 1'b0);
    repeat (150) @(negedge clock);
    check("boot_to held", 32'(bootstrap), 32'd1);
    check("boot_to held select", 32'(select), 32'b0011);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
